multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Moore control sequencer for the multicycle ARM-subset datapath. Sequences fetch, decode, execute, memory and writeback.
- Drives imm_src, which selects the extend unit's mode: 8-bit zero-extend, 12-bit sign-extend, or 24-bit branch offset. Also drives ALU operand muxes, ALU op and all write enables.
- Stalls on a single mem_ready handshake shared by instruction and data memory.
- Counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of instr_count; wraps modulo 2^COUNT_WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  current instruction register contents
- flag_z  input  1  zero flag from status register
- mem_ready  input  1  memory completes the access in this cycle
- pc_write  output  1  PC load enable
- ir_write  output  1  instruction register load enable
- adr_src  output  1  memory address: 0=PC, 1=ALUOut
- mem_write  output  1  data memory write request
- reg_write  output  1  register file write enable
- result_src  output  2  00=ALUOut, 01=read data, 10=ALU result direct
- alu_src_a  output  2  00=reg A, 01=PC
- alu_src_b  output  2  00=reg B, 01=extended imm, 10=constant 4
- alu_control  output  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- imm_src  output  2  00 zero-ext imm[7:0], 01 sign-ext imm[11:0], 10 sign-ext imm[23:0]<<2
- illegal  output  1  one-cycle pulse on an undecodable instruction
- instr_count  output  COUNT_WIDTH  retired-instruction counter
- state_out  output  4  current state encoding, for debug

Behaviour:
- Reset is asynchronous, active-low.
  - State goes to IDLE(0) and instr_count to 0.
  - All outputs are 0 while in reset and in IDLE.
  - IDLE goes to FETCH unconditionally on the first clock after release.
- State encodings: FETCH 1, DECODE 2, EXECR 3, EXECI 4, ALUWB 5, MEMADR 6, MEMRD 7, MEMWB 8, MEMWR 9, BRANCH 10.
- Decode fields:
  - op = instr[27:26]: 00 DP, 01 MEM, 10 B, 11 illegal.
  - I = instr[25]; cmd = instr[24:21]; U = instr[23]; L = instr[20].
  - cond = instr[31:28]: 1110 AL, 0000 EQ (flag_z=1), 0001 NE (flag_z=0); any other value is illegal.
- Defaults: every output not listed for a state is 0.
- FETCH:
  - Drives adr_src=0, alu_src_a=01, alu_src_b=10, ADD, result_src=10.
  - ir_write=pc_write=1 only in the cycle mem_ready=1; that cycle transitions to DECODE. Otherwise the state holds with enables 0.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=10, ADD (computes PC+8).
  - Illegal op, cond or cmd: illegal=1 for this cycle, go to FETCH, not counted.
  - Condition false: go to FETCH, counted as retired.
  - Otherwise: DP with I=0 goes to EXECR; DP with I=1 goes to EXECI; MEM goes to MEMADR; B goes to BRANCH.
- Legal DP cmd values: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP.
- EXECR / EXECI:
  - Operands: alu_src_a=00; alu_src_b=00 (EXECR) or 01 with imm_src=00 (EXECI).
  - alu_control is taken from cmd; CMP uses SUB.
  - Next state: ALUWB, except CMP goes to FETCH, counted.
- ALUWB: result_src=00, reg_write=1; go to FETCH, counted.
- MEMADR: alu_src_a=00, alu_src_b=01, imm_src=01; ADD if U=1, SUB if U=0. Next state is MEMRD if L=1, otherwise MEMWR.
- MEMRD: adr_src=1; hold until mem_ready=1, then go to MEMWB.
- MEMWB: result_src=01, reg_write=1; go to FETCH, counted.
- MEMWR: adr_src=1, mem_write=1, held every cycle until mem_ready=1; then go to FETCH, counted.
- BRANCH: alu_src_a=01, alu_src_b=01, imm_src=10, ADD, result_src=10, pc_write=1; go to FETCH, counted.
- Counter:
  - instr_count increments by 1 on the clock edge that enters FETCH from a counted path. It wraps to 0 from all-ones.
  - Exactly one increment per retired instruction.
- mem_ready is ignored in every state other than FETCH, MEMRD and MEMWR.
- Reset asserted mid-instruction: immediate return to IDLE with all outputs 0. No partial write is completed.

Test Plan:
- Reset release; instr=0xE2811005 (ADD imm), mem_ready=1 constant -> states IDLE,FETCH,DECODE,EXECI,ALUWB,FETCH. EXECI drives imm_src=00, alu_src_b=01. ALUWB drives reg_write=1. instr_count=1.
- LDR 0xE5912004 with mem_ready low 3 cycles in MEMRD -> MEMADR drives imm_src=01 and ADD. MEMRD holds 3 extra cycles with reg_write=0. MEMWB drives result_src=01. Total 5 states + 3 stall cycles; count +1.
- STR with U=0 (0xE5012004), mem_ready low 2 cycles -> MEMADR drives SUB. mem_write=1 for 3 consecutive cycles and drops on FETCH entry.
- Branch 0x0A000010 (BEQ): with flag_z=1 -> BRANCH drives imm_src=10, pc_write=1. With flag_z=0 -> DECODE goes directly to FETCH, no pc_write, count still +1.
- Illegal instructions 0xEC000000 (op=11) and 0xE0600000 (cmd=0011) -> illegal pulses one cycle in DECODE, back to FETCH, count unchanged.
- COUNT_WIDTH=4 with 17 CMP instructions -> count wraps 15 to 0 and ends at 1. rst_n dropped during MEMWR -> mem_write falls to 0 asynchronously and state_out=0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Moore control sequencer for the multicycle ARM-subset datapath; outputs follow the state in the same cycle.
// Stalls in FETCH, MEMRD and MEMWR until mem_ready; counts retired instructions.
module multicycle_control_fsm #(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [31:0]            instr,
    input  logic                   flag_z,
    input  logic                   mem_ready,
    output logic                   pc_write,
    output logic                   ir_write,
    output logic                   adr_src,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic [1:0]             result_src,
    output logic [1:0]             alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_control,
    output logic [1:0]             imm_src,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic [3:0]             state_out
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXECR  = 4'd3,
        S_EXECI  = 4'd4,
        S_ALUWB  = 4'd5,
        S_MEMADR = 4'd6,
        S_MEMRD  = 4'd7,
        S_MEMWB  = 4'd8,
        S_MEMWR  = 4'd9,
        S_BRANCH = 4'd10
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [COUNT_WIDTH-1:0]   r_instr_count;
    logic                     w_retire;

    logic [1:0] w_op;
    logic       w_i;
    logic [3:0] w_cmd;
    logic       w_u;
    logic       w_l;
    logic [3:0] w_cond;
    logic       w_cond_legal;
    logic       w_cond_pass;
    logic       w_cmd_legal;
    logic       w_is_cmp;
    logic [2:0] w_dp_alu;
    logic       w_illegal;

    assign w_op   = instr[27:26];
    assign w_i    = instr[25];
    assign w_cmd  = instr[24:21];
    assign w_u    = instr[23];
    assign w_l    = instr[20];
    assign w_cond = instr[31:28];

    assign w_cond_legal = (w_cond == 4'hE) || (w_cond == 4'h0) || (w_cond == 4'h1);
    assign w_cond_pass  = (w_cond == 4'hE) || ((w_cond == 4'h0) && flag_z) ||
                          ((w_cond == 4'h1) && !flag_z);
    assign w_is_cmp     = (w_cmd == 4'b1010);

    always_comb begin
        w_cmd_legal = 1'b1;
        w_dp_alu    = 3'b000;
        case (w_cmd)
            4'b0100: w_dp_alu = 3'b000;
            4'b0010: w_dp_alu = 3'b001;
            4'b0000: w_dp_alu = 3'b010;
            4'b1100: w_dp_alu = 3'b011;
            4'b1010: w_dp_alu = 3'b001;
            default: w_cmd_legal = 1'b0;
        endcase
    end

    // cmd is only meaningful for data-processing; MEM/B reuse those bits as U/L/offset.
    assign w_illegal = (w_op == 2'b11) || !w_cond_legal || ((w_op == 2'b00) && !w_cmd_legal);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_instr_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_instr_count <= r_instr_count + COUNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        adr_src     = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        imm_src     = 2'b00;
        illegal     = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    w_next   = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                if (w_illegal) begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end else if (!w_cond_pass) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    case (w_op)
                        2'b00:   w_next = w_i ? S_EXECI : S_EXECR;
                        2'b01:   w_next = S_MEMADR;
                        default: w_next = S_BRANCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: begin
                alu_src_b   = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                alu_control = w_dp_alu;
                if (w_is_cmp) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else begin
                    w_next = S_ALUWB;
                end
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                w_retire  = 1'b1;
                w_next    = S_FETCH;
            end
            S_MEMADR: begin
                alu_src_b   = 2'b01;
                imm_src     = 2'b01;
                alu_control = w_u ? 3'b000 : 3'b001;
                w_next      = w_l ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                imm_src    = 2'b10;
                result_src = 2'b10;
                pc_write   = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign instr_count = r_instr_count;
    assign state_out   = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized scoreboard bench for multicycle_control_fsm; a 32-bit and a 4-bit counter instance share stimulus.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] instr;
    logic        flag_z;
    logic        mem_ready;

    logic        a_pcw, a_irw, a_adr, a_mw, a_rw, a_ill;
    logic [1:0]  a_rs, a_sa, a_sb, a_imm;
    logic [2:0]  a_alu;
    logic [31:0] a_count;
    logic [3:0]  a_state;

    logic        b_pcw, b_irw, b_adr, b_mw, b_rw, b_ill;
    logic [1:0]  b_rs, b_sa, b_sb, b_imm;
    logic [2:0]  b_alu;
    logic [3:0]  b_count;
    logic [3:0]  b_state;

    multicycle_control_fsm #(.COUNT_WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .flag_z(flag_z), .mem_ready(mem_ready),
        .pc_write(a_pcw), .ir_write(a_irw), .adr_src(a_adr), .mem_write(a_mw), .reg_write(a_rw),
        .result_src(a_rs), .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_control(a_alu),
        .imm_src(a_imm), .illegal(a_ill), .instr_count(a_count), .state_out(a_state)
    );

    multicycle_control_fsm #(.COUNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .flag_z(flag_z), .mem_ready(mem_ready),
        .pc_write(b_pcw), .ir_write(b_irw), .adr_src(b_adr), .mem_write(b_mw), .reg_write(b_rw),
        .result_src(b_rs), .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_control(b_alu),
        .imm_src(b_imm), .illegal(b_ill), .instr_count(b_count), .state_out(b_state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic        pcw, irw, adr, mw, rw;
        logic [1:0]  rs, sa, sb;
        logic [2:0]  alu;
        logic [1:0]  imm;
        logic        ill;
        logic [31:0] cnt;
    } rec_t;

    rec_t        sb_q[$];
    int          checks = 0;
    int          passed = 0;
    int          exp_cnt = 0;
    logic [31:0] cur_instr = 32'h0;
    bit          cur_z = 1'b0;

    function automatic rec_t mk(input int st, input bit pcw, input bit irw, input bit adr,
                                input bit mw, input bit rw, input int rs, input int sa,
                                input int sb, input int alu, input int imm, input bit ill);
        rec_t r;
        r.st  = 4'(st);
        r.pcw = pcw; r.irw = irw; r.adr = adr; r.mw = mw; r.rw = rw;
        r.rs  = 2'(rs); r.sa = 2'(sa); r.sb = 2'(sb);
        r.alu = 3'(alu); r.imm = 2'(imm); r.ill = ill;
        r.cnt = 32'(exp_cnt);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    rec_t mon_e, mon_a;
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            mon_a.st = a_state;
            mon_a.pcw = a_pcw; mon_a.irw = a_irw; mon_a.adr = a_adr; mon_a.mw = a_mw; mon_a.rw = a_rw;
            mon_a.rs = a_rs; mon_a.sa = a_sa; mon_a.sb = a_sb;
            mon_a.alu = a_alu; mon_a.imm = a_imm; mon_a.ill = a_ill;
            mon_a.cnt = a_count;
            checks++;
            if (mon_a === mon_e) passed++;
            else $display("FAIL cycle @%0t: got %h, expected %h", $time, mon_a, mon_e);
            checks++;
            if (b_count === mon_e.cnt[3:0]) passed++;
            else $display("FAIL count4 @%0t: got %0d, expected %0d", $time, b_count, mon_e.cnt[3:0]);
        end
    end

    task automatic step(input bit mr, input rec_t r);
        @(posedge clk);
        #1;
        instr     = cur_instr;
        flag_z    = cur_z;
        mem_ready = mr;
        sb_q.push_back(r);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_cnt = 0;
        sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Reference: the spec's per-instruction cycle schedule, expanded from decoded fields.
    task automatic run_instr(input logic [31:0] ins, input bit z, input int fs, input int ms,
                             input bit abort_wr);
        logic [1:0] op;
        logic [3:0] cmd, cond;
        bit         iflag, u, l, cond_ok, pass, cmd_ok, ill;
        int         alu;
        op = ins[27:26]; iflag = ins[25]; cmd = ins[24:21];
        u = ins[23]; l = ins[20]; cond = ins[31:28];
        cond_ok = (cond == 4'hE) || (cond == 4'h0) || (cond == 4'h1);
        pass    = (cond == 4'hE) || (cond == 4'h0 && z) || (cond == 4'h1 && !z);
        cmd_ok  = 1'b1;
        alu     = 0;
        case (cmd)
            4'b0100: alu = 0;
            4'b0010: alu = 1;
            4'b0000: alu = 2;
            4'b1100: alu = 3;
            4'b1010: alu = 1;
            default: cmd_ok = 1'b0;
        endcase
        ill = (op == 2'b11) || !cond_ok || (op == 2'b00 && !cmd_ok);
        cur_instr = ins;
        cur_z     = z;
        for (int k = 0; k < fs; k++) step(1'b0, mk(1, 0, 0, 0, 0, 0, 2, 1, 2, 0, 0, 0));
        step(1'b1, mk(1, 1, 1, 0, 0, 0, 2, 1, 2, 0, 0, 0));
        step(1'($urandom), mk(2, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, ill));
        if (ill) return;
        if (!pass) begin
            exp_cnt++;
            return;
        end
        case (op)
            2'b00: begin
                step(1'($urandom), mk(iflag ? 4 : 3, 0, 0, 0, 0, 0, 0, 0, iflag ? 1 : 0, alu, 0, 0));
                if (cmd != 4'b1010) step(1'($urandom), mk(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
                exp_cnt++;
            end
            2'b01: begin
                step(1'($urandom), mk(6, 0, 0, 0, 0, 0, 0, 0, 1, u ? 0 : 1, 1, 0));
                if (l) begin
                    for (int k = 0; k < ms; k++) step(1'b0, mk(7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                    step(1'b1, mk(7, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
                    step(1'($urandom), mk(8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
                    exp_cnt++;
                end else begin
                    if (abort_wr) begin
                        step(1'b0, mk(9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
                        return;
                    end
                    for (int k = 0; k < ms; k++) step(1'b0, mk(9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
                    step(1'b1, mk(9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
                    exp_cnt++;
                end
            end
            default: begin
                step(1'($urandom), mk(10, 1, 0, 0, 0, 0, 2, 1, 1, 0, 2, 0));
                exp_cnt++;
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [3:0]  cond, cmd;
        logic [31:0] r;
        int          pick;
        logic [3:0]  legal_cmd [5];
        legal_cmd[0] = 4'b0100; legal_cmd[1] = 4'b0010; legal_cmd[2] = 4'b0000;
        legal_cmd[3] = 4'b1100; legal_cmd[4] = 4'b1010;
        pick = int'($urandom_range(0, 7));
        if (pick < 4)       cond = 4'hE;
        else if (pick == 4) cond = 4'h0;
        else if (pick == 5) cond = 4'h1;
        else                cond = 4'($urandom);
        if ($urandom_range(0, 4) == 0) cmd = 4'($urandom);
        else                           cmd = legal_cmd[$urandom_range(0, 4)];
        r = $urandom;
        r[31:28] = cond;
        r[27:26] = 2'($urandom_range(0, 3));
        r[24:21] = cmd;
        return r;
    endfunction

    initial begin
        rst_n = 1'b0; instr = 32'h0; flag_z = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {28'h0, a_state}, 32'h0);
        check("reset_outputs", {16'h0, a_pcw, a_irw, a_adr, a_mw, a_rw, a_rs, a_sa, a_sb, a_alu, a_imm, a_ill}, 32'h0);
        check("reset_count", a_count, 32'h0);
        release_reset();

        run_instr(32'hE2811005, 1'b0, 0, 0, 1'b0);
        run_instr(32'hE5912004, 1'b0, 0, 3, 1'b0);
        run_instr(32'hE5012004, 1'b0, 0, 2, 1'b0);
        run_instr(32'h0A000010, 1'b1, 0, 0, 1'b0);
        run_instr(32'h0A000010, 1'b0, 1, 0, 1'b0);
        run_instr(32'hEC000000, 1'b0, 0, 0, 1'b0);
        run_instr(32'hE0600000, 1'b0, 2, 0, 1'b0);
        check("count_after_directed", a_count, 32'd5);

        repeat (60) run_instr(rand_instr(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);

        @(negedge clk);
        #2;
        rst_n = 1'b0;
        release_reset();
        repeat (17) run_instr(32'hE1500000, 1'($urandom), $urandom_range(0, 1), 0, 1'b0);
        run_instr(32'hE5012004, 1'b0, 0, 2, 1'b1);
        @(negedge clk);
        #2;
        check("wrap_count4", {28'h0, b_count}, 32'd1);
        check("count32_17", a_count, 32'd17);
        rst_n = 1'b0;
        #1;
        check("async_mem_write", {31'h0, a_mw}, 32'h0);
        check("async_state", {28'h0, a_state}, 32'h0);
        check("async_count", a_count, 32'h0);

        release_reset();
        repeat (5) run_instr(rand_instr(), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        @(negedge clk);
        #2;
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
